vx_bits_insert_stream: RTL
==========================

Name: vx_bits_insert_stream

Overview:
- Streaming, handshaked bit-field insert/remove unit: places an S-bit field into, or removes it from, an N-bit word at a runtime position.
- Serves LANES independent lanes that share one valid/ready handshake.
- One registered output stage plus a one-entry skid buffer: full throughput, latency 1.
- Sits in the SIMT datapath and memory request packing paths, wherever tag/field insertion positions are decided at run time.

Parameters:
- N, 8, base data width per lane (>=1)
- S, 4, field width per lane; 0 = passthrough mode
- LANES, 1, number of parallel lanes (>=1)
- CNT_W, 32, width of the saturating clamp counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_in  in  1  input beat valid
- ready_in  out  1  unit can accept a beat
- mode_in  in  1  0 = INSERT, 1 = REMOVE
- pos_in  in  clog2(N+1)  bit position of the field, shared by all lanes
- data_in  in  LANES*(N+S)  INSERT: low N bits per lane are used and the upper S are ignored; REMOVE: the full N+S-bit word
- field_in  in  LANES*UP(S)  field to insert; ignored in REMOVE
- valid_out  out  1  output beat valid
- ready_out  in  1  downstream accepts
- data_out  out  LANES*(N+S)  INSERT: N+S-bit result; REMOVE: N-bit result zero-extended
- field_out  out  LANES*UP(S)  REMOVE: extracted field; INSERT: zero
- clamp_out  out  1  pos_in was out of range for this beat
- clamp_cnt  out  CNT_W  saturating count of clamped beats accepted

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - valid_out=0, ready_in=0, skid buffer empty, clamp_cnt=0.
  - data_out, field_out and clamp_out are 0.
  - ready_in rises on the first clk edge after reset deasserts.
- Position clamp: effective pos p = min(pos_in, N). clamp_out=1 iff pos_in>N. This applies in both modes.
- INSERT, per lane, with d = the low N bits of data_in:
  - p=0: out={d,f}.
  - p=N: out={f,d}.
  - otherwise: out={d[N-1:p], f, d[p-1:0]}.
- REMOVE, per lane, with w = data_in:
  - field_out=w[p+S-1:p].
  - data_out={S'b0, w[N+S-1:p+S], w[p-1:0]}, with the boundary cases p=0 and p=N handled without zero-width slices.
- S=0 passthrough: data_out=data_in, field_out=0, mode_in is ignored. The clamp logic stays active.
- Implementation is a shift/mask network, not a case per position; it must be synthesizable for any N up to 256.
- Handshake:
  - A beat is accepted when valid_in && ready_in.
  - A beat is delivered when valid_out && ready_out.
  - Result appears on the outputs the cycle after acceptance.
  - Output register (OR) plus skid register (SK). ready_in = !SK_full.
  - On accept with OR empty, or OR draining this cycle: the beat goes to OR.
  - On accept with OR full and not draining: the beat goes to SK.
  - When OR drains and SK is full: SK moves to OR and SK empties.
  - Order is preserved and there is no drop or duplication.
  - Sustained valid_in=ready_out=1 gives 1 beat/cycle.
- valid_out stays asserted and outputs stay stable while ready_out=0.
- Simultaneous accept and drain with SK empty: the new beat replaces OR and SK stays empty.
- clamp_cnt increments on each accepted beat with clamp=1 and saturates at all-ones with no wrap.
- Reset mid-stream drops all buffered beats immediately.
- All lanes share mode, pos and handshake. There is no per-lane stall.

Decomposition:
- Package vx_bits_pkg holds:
  - mode constants BITS_MODE_INSERT=1'b0, BITS_MODE_REMOVE=1'b1;
  - the pos width function;
  - the per-beat payload struct {data, field, clamp}.
- Sub-module vx_bits_shift_lane: purely combinational single-lane insert/remove network, instantiated LANES times.
- The top level owns the clamp, the OR/SK buffering and the counter.

Test Plan:
- INSERT, N=8, S=4, data 0xA5, field 0x3, pos 4, ready_out=1 -> next cycle valid_out=1, data_out=0xA35, field_out=0, clamp_out=0.
- REMOVE, data_in 0xA35, pos 4 -> data_out=0x0A5, field_out=0x3. The same with pos 0 -> data_out=0x0A3, field_out=0x5.
- INSERT, pos 9 (>N), data 0xA5, field 0x3 -> data_out=0x3A5, clamp_out=1, clamp_cnt=1. With CNT_W=2, the 5th clamped beat leaves clamp_cnt=3.
- Backpressure: issue beats B0, B1, B2 back-to-back with ready_out=0 ->
  - B0 is held in OR, B1 in SK, ready_in=0 and B2 stalls;
  - after ready_out=1, B0, B1, B2 are delivered in order on consecutive cycles with no loss.
- Reset asserted mid-stream with OR and SK full -> valid_out=0, ready_in=0 and clamp_cnt=0 asynchronously. After release, the first new beat is delivered correctly.
- LANES=4, S=0 -> data_out equals data_in per lane with latency 1; ramp throughput of 1 beat/cycle is sustained.

Source files
------------

// File: rtl/vx_bits_pkg.sv
// Shared constants and helpers for the bit-field insert/remove stream.
// No ports: mode encodings and width helpers only.
package vx_bits_pkg;

  localparam logic BITS_MODE_INSERT = 1'b0;
  localparam logic BITS_MODE_REMOVE = 1'b1;

  function automatic int pos_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int up(input int s);
    return (s > 0) ? s : 1;
  endfunction

endpackage

// File: rtl/vx_bits_insert_stream_if.sv
// Handshake bundle for vx_bits_insert_stream.
// master drives beats and ready_out; slave is the unit.
interface vx_bits_insert_stream_if #(
  parameter int N     = 8,
  parameter int S     = 4,
  parameter int LANES = 1,
  parameter int CNT_W = 32
);
  import vx_bits_pkg::*;

  localparam int PW = pos_w(N);
  localparam int W  = N + S;
  localparam int FW = up(S);

  logic                  valid_in;
  logic                  ready_in;
  logic                  mode_in;
  logic [PW-1:0]         pos_in;
  logic [LANES*W-1:0]    data_in;
  logic [LANES*FW-1:0]   field_in;
  logic                  valid_out;
  logic                  ready_out;
  logic [LANES*W-1:0]    data_out;
  logic [LANES*FW-1:0]   field_out;
  logic                  clamp_out;
  logic [CNT_W-1:0]      clamp_cnt;

  modport master (
    output valid_in, mode_in, pos_in,
    output data_in, field_in, ready_out,
    input  ready_in, valid_out, data_out,
    input  field_out, clamp_out, clamp_cnt
  );

  modport slave (
    input  valid_in, mode_in, pos_in,
    input  data_in, field_in, ready_out,
    output ready_in, valid_out, data_out,
    output field_out, clamp_out, clamp_cnt
  );

endinterface

// File: rtl/vx_bits_shift_lane.sv
// Combinational single-lane field insert/remove shift/mask network.
// i_mode/i_pos/i_data/i_field in; o_data/o_field out.
module vx_bits_shift_lane
  import vx_bits_pkg::*;
#(
  parameter int N  = 8,
  parameter int S  = 4,
  parameter int PW = pos_w(N),
  parameter int W  = N + S,
  parameter int FW = up(S)
) (
  input  logic          i_mode,
  input  logic [PW-1:0] i_pos,
  input  logic [W-1:0]  i_data,
  input  logic [FW-1:0] i_field,
  output logic [W-1:0]  o_data,
  output logic [FW-1:0] o_field
);

  if (S == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{i_mode, i_pos, i_field};
    assign o_data   = i_data;
    assign o_field  = '0;
  end else begin : g_net
    logic [W-1:0] w_lo;
    logic [W-1:0] w_d;
    logic [W-1:0] w_f;
    logic [W-1:0] w_ins;
    logic [W-1:0] w_rem;
    logic         w_rm;

    // w_lo selects the bits below the field position
    assign w_lo  = ~({W{1'b1}} << i_pos);
    assign w_d   = {{S{1'b0}}, i_data[N-1:0]};
    assign w_f   = {{N{1'b0}}, i_field};
    // upper part of d moves up by S to open the gap
    assign w_ins = (w_d & w_lo)
                 | (w_f << i_pos)
                 | ((w_d & ~w_lo) << S);
    // upper part of w moves down by S to close the gap
    assign w_rem = (i_data & w_lo)
                 | ((i_data >> S) & ~w_lo);
    assign w_rm  = (i_mode == BITS_MODE_REMOVE);

    assign o_data  = w_rm ? w_rem : w_ins;
    assign o_field = w_rm ? FW'(i_data >> i_pos) : '0;
  end

endmodule

// File: rtl/vx_bits_insert_stream.sv
// Streaming multi-lane bit-field insert/remove with output reg + skid.
// clk, reset (async high), bus: slave side of the stream interface.
module vx_bits_insert_stream
  import vx_bits_pkg::*;
#(
  parameter int N     = 8,
  parameter int S     = 4,
  parameter int LANES = 1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  vx_bits_insert_stream_if.slave bus
);

  localparam int PW = pos_w(N);
  localparam int W  = N + S;
  localparam int FW = up(S);

  typedef struct packed {
    logic [LANES*W-1:0]  data;
    logic [LANES*FW-1:0] field;
    logic                clamp;
  } beat_t;

  logic                w_clamp;
  logic [PW-1:0]       w_pos;
  logic [LANES*W-1:0]  w_data;
  logic [LANES*FW-1:0] w_field;
  beat_t               w_beat;
  logic                w_acc;
  logic                w_drn;

  beat_t            r_or;
  beat_t            r_sk;
  logic             r_or_v;
  logic             r_sk_v;
  logic             r_rdy;
  logic [CNT_W-1:0] r_cnt;

  assign w_clamp = bus.pos_in > PW'(N);
  assign w_pos   = w_clamp ? PW'(N) : bus.pos_in;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vx_bits_shift_lane #(
      .N (N),
      .S (S)
    ) u_lane (
      .i_mode  (bus.mode_in),
      .i_pos   (w_pos),
      .i_data  (bus.data_in[l*W +: W]),
      .i_field (bus.field_in[l*FW +: FW]),
      .o_data  (w_data[l*W +: W]),
      .o_field (w_field[l*FW +: FW])
    );
  end

  assign w_beat = {w_data, w_field, w_clamp};

  // r_rdy keeps ready_in low until the first edge after reset
  assign bus.ready_in  = r_rdy & ~r_sk_v;
  assign bus.valid_out = r_or_v;
  assign bus.data_out  = r_or.data;
  assign bus.field_out = r_or.field;
  assign bus.clamp_out = r_or.clamp;
  assign bus.clamp_cnt = r_cnt;

  assign w_acc = bus.valid_in & bus.ready_in;
  assign w_drn = r_or_v & bus.ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy  <= 1'b0;
      r_or_v <= 1'b0;
      r_sk_v <= 1'b0;
      r_or   <= '0;
      r_sk   <= '0;
    end else begin
      r_rdy <= 1'b1;
      // skid full implies no accept this cycle
      if (w_drn && r_sk_v) begin
        r_or   <= r_sk;
        r_sk_v <= 1'b0;
      end else if (w_acc && (!r_or_v || w_drn)) begin
        r_or   <= w_beat;
        r_or_v <= 1'b1;
      end else if (w_acc) begin
        r_sk   <= w_beat;
        r_sk_v <= 1'b1;
      end else if (w_drn) begin
        r_or_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_acc && w_clamp && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
